// File: rtl/fetch_stage_pkg.sv
// Shared CPU constants for the IF stage: reset vector, nop encoding and
// PC-source select codes used by the PC register's priority mux.
package fetch_stage_pkg;

   localparam logic [31:0] RESET_PC = 32'h0000_3000;
   localparam logic [31:0] NOP      = 32'h0000_0000;

   localparam logic [1:0] PCSEL_SEQ  = 2'd0;
   localparam logic [1:0] PCSEL_NPC  = 2'd1;
   localparam logic [1:0] PCSEL_JR   = 2'd2;
   localparam logic [1:0] PCSEL_HOLD = 2'd3;

endpackage

// File: rtl/fetch_stage_pc_reg.sv
// Fetch PC register: priority select between hold, jr, decode next-PC and
// sequential PC+4, with every source forced to word alignment.
module pc_reg #(
   parameter logic [31:0] RESET_PC = fetch_stage_pkg::RESET_PC
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        stall_i,
   input  logic        redirect_npc_i,
   input  logic [31:0] npc_target_i,
   input  logic        redirect_jr_i,
   input  logic [31:0] jr_target_i,
   output logic [31:0] pc_o
);
   import fetch_stage_pkg::*;

   logic [1:0]  pc_sel;
   logic [31:0] pc_raw;
   logic [31:0] pc_d;
   logic [31:0] pc_q;

   // jr outranks npc; decode never raises both, but the outcome stays defined.
   always_comb begin
      pc_sel = PCSEL_SEQ;
      if (stall_i)             pc_sel = PCSEL_HOLD;
      else if (redirect_jr_i)  pc_sel = PCSEL_JR;
      else if (redirect_npc_i) pc_sel = PCSEL_NPC;
   end

   always_comb begin
      pc_raw = pc_q + 32'd4;
      case (pc_sel)
         PCSEL_HOLD: pc_raw = pc_q;
         PCSEL_JR:   pc_raw = jr_target_i;
         PCSEL_NPC:  pc_raw = npc_target_i;
         default:    pc_raw = pc_q + 32'd4;
      endcase
      pc_d = {pc_raw[31:2], 2'b00};
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) pc_q <= RESET_PC;
      else         pc_q <= pc_d;
   end

   assign pc_o = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// IF stage: PC register, combinational instruction-ROM addressing and the
// IF/ID pipeline register. Delay-slot ISA, so nothing here is ever flushed.
module fetch_stage #(
   parameter logic [31:0] RESET_PC = fetch_stage_pkg::RESET_PC,
   parameter int          IM_AW    = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             stall,
   input  logic             redirect_npc,
   input  logic [31:0]      npc_target,
   input  logic             redirect_jr,
   input  logic [31:0]      jr_target,
   output logic [IM_AW-1:0] im_addr,
   input  logic [31:0]      im_rdata,
   output logic [31:0]      pc_f,
   output logic [31:0]      instr_d,
   output logic [31:0]      pc_d,
   output logic [31:0]      pc4_d,
   output logic             valid_d
);
   import fetch_stage_pkg::*;

   logic [31:0] instr_q;
   logic [31:0] pcd_q;
   logic [31:0] pc4d_q;
   logic        valid_q;

   pc_reg #(.RESET_PC(RESET_PC)) u_pc_reg (
      .clk_i          (clk),
      .reset_i        (reset),
      .stall_i        (stall),
      .redirect_npc_i (redirect_npc),
      .npc_target_i   (npc_target),
      .redirect_jr_i  (redirect_jr),
      .jr_target_i    (jr_target),
      .pc_o           (pc_f)
   );

   // Offset from the ROM base; PCs outside the ROM simply wrap modulo its depth.
   assign im_addr = IM_AW'((pc_f - RESET_PC) >> 2);

   always_ff @(posedge clk) begin
      if (reset) begin
         instr_q <= NOP;
         pcd_q   <= RESET_PC;
         pc4d_q  <= RESET_PC + 32'd4;
         valid_q <= 1'b0;
      end else if (!stall) begin
         instr_q <= im_rdata;
         pcd_q   <= pc_f;
         pc4d_q  <= pc_f + 32'd4;
         valid_q <= 1'b1;
      end
   end

   assign instr_d = instr_q;
   assign pc_d    = pcd_q;
   assign pc4_d   = pc4d_q;
   assign valid_d = valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed plus randomized bench for fetch_stage with a scoreboard of
// expected IF/ID contents ({instr, pc, pc+4}) queued at fetch time.
module tb_fetch_stage;

   localparam logic [31:0] BASE = 32'h0000_3000;
   localparam int          AW   = 10;

   logic          clk;
   logic          reset;
   logic          stall;
   logic          redirect_npc;
   logic [31:0]   npc_target;
   logic          redirect_jr;
   logic [31:0]   jr_target;
   logic [AW-1:0] im_addr;
   logic [31:0]   im_rdata;
   logic [31:0]   pc_f;
   logic [31:0]   instr_d;
   logic [31:0]   pc_d;
   logic [31:0]   pc4_d;
   logic          valid_d;

   int checks = 0;
   int errors = 0;

   logic [95:0] exp_q[$];
   logic [95:0] last_exp;
   logic        last_valid;
   logic [31:0] pc_m;

   fetch_stage #(.RESET_PC(BASE), .IM_AW(AW)) dut (
      .clk          (clk),
      .reset        (reset),
      .stall        (stall),
      .redirect_npc (redirect_npc),
      .npc_target   (npc_target),
      .redirect_jr  (redirect_jr),
      .jr_target    (jr_target),
      .im_addr      (im_addr),
      .im_rdata     (im_rdata),
      .pc_f         (pc_f),
      .instr_d      (instr_d),
      .pc_d         (pc_d),
      .pc4_d        (pc4_d),
      .valid_d      (valid_d)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Instruction ROM: word i holds 0x2400_0001 + i.
   assign im_rdata = 32'h2400_0001 + {{(32-AW){1'b0}}, im_addr};

   function automatic logic [AW-1:0] exp_addr(input logic [31:0] pc);
      logic [31:0] off;
      off = (pc - BASE) >> 2;
      return off[AW-1:0];
   endfunction

   function automatic logic [31:0] rom(input logic [31:0] pc);
      return 32'h2400_0001 + {{(32-AW){1'b0}}, exp_addr(pc)};
   endfunction

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %b expected %b", tag, obs, exp);
      end
   endtask

   // One cycle: drive at the falling edge, check fetch side, clock, check IF/ID.
   task automatic step(input logic rst, input logic st,
                       input logic npc, input logic [31:0] npc_t,
                       input logic jr,  input logic [31:0] jr_t);
      reset        = rst;
      stall        = st;
      redirect_npc = npc;
      npc_target   = npc_t;
      redirect_jr  = jr;
      jr_target    = jr_t;
      #1;
      if (!rst) begin
         chk32("pc_f_pre", pc_f, pc_m);
         chk32("im_addr", {{(32-AW){1'b0}}, im_addr}, {{(32-AW){1'b0}}, exp_addr(pc_m)});
         if (!st) exp_q.push_back({rom(pc_m), pc_m, pc_m + 32'd4});
      end
      @(posedge clk);
      #1;
      if (rst)       pc_m = BASE;
      else if (st)   pc_m = pc_m;
      else if (jr)   pc_m = {jr_t[31:2], 2'b00};
      else if (npc)  pc_m = {npc_t[31:2], 2'b00};
      else           pc_m = pc_m + 32'd4;

      if (rst) begin
         exp_q.delete();
         last_exp   = {32'h0, BASE, BASE + 32'd4};
         last_valid = 1'b0;
      end else if (!st) begin
         chk1("sb_nonempty", exp_q.size() != 0, 1'b1);
         if (exp_q.size() != 0) last_exp = exp_q.pop_front();
         last_valid = 1'b1;
      end
      if (!rst && !st && jr && npc)
         chk32("jr_wins", pc_f, {jr_t[31:2], 2'b00});
      chk32("pc_f_post", pc_f, pc_m);
      chk32("instr_d", instr_d, last_exp[95:64]);
      chk32("pc_d", pc_d, last_exp[63:32]);
      chk32("pc4_d", pc4_d, last_exp[31:0]);
      chk1("valid_d", valid_d, last_valid);
      @(negedge clk);
   endtask

   initial begin
      logic st, npc, jr;
      logic [31:0] t1, t2;
      reset = 1'b0; stall = 1'b0; redirect_npc = 1'b0; redirect_jr = 1'b0;
      npc_target = 32'h0; jr_target = 32'h0;
      pc_m = BASE; last_exp = '0; last_valid = 1'b0;
      @(negedge clk);

      // Reset, then free-run from the reset vector.
      step(1, 0, 0, 32'h0, 0, 32'h0);
      chk32("reset_instr", instr_d, 32'h0);
      for (int i = 0; i < 4; i++) step(0, 0, 0, 32'h0, 0, 32'h0);

      // Back to 0x3008, then npc redirect with delay slot entering IF/ID.
      step(0, 0, 0, 32'h0, 1, 32'h0000_3008);
      step(0, 0, 1, 32'h0000_3040, 0, 32'h0);
      chk32("delay_slot_instr", instr_d, 32'h2400_0003);
      chk32("delay_slot_pc4", pc4_d, 32'h0000_300C);
      chk32("npc_target_pc", pc_f, 32'h0000_3040);

      // Stall with jr pending for 3 cycles, then released.
      for (int i = 0; i < 3; i++) step(0, 1, 0, 32'h0, 1, 32'h0000_3100);
      chk32("stall_frozen_pc", pc_f, 32'h0000_3040);
      step(0, 0, 0, 32'h0, 1, 32'h0000_3100);
      chk32("jr_after_stall", pc_f, 32'h0000_3100);

      // Both redirects high, then misaligned jr target.
      step(0, 0, 1, 32'h0000_3300, 1, 32'h0000_3200);
      step(0, 0, 0, 32'h0, 1, 32'h0000_3203);
      chk32("jr_aligned", pc_f, 32'h0000_3200);

      // Reset mid-stream while stalled at 0x3050.
      step(0, 0, 1, 32'h0000_3050, 0, 32'h0);
      step(1, 1, 0, 32'h0, 0, 32'h0);
      chk32("midreset_pc", pc_f, 32'h0000_3000);
      chk1("midreset_valid", valid_d, 1'b0);
      step(0, 0, 0, 32'h0, 0, 32'h0);

      // Below the ROM base: address wraps to the top word.
      step(0, 0, 0, 32'h0, 1, 32'h0000_2FFC);
      chk32("below_base_addr", {{(32-AW){1'b0}}, im_addr}, 32'h0000_03FF);
      step(0, 0, 0, 32'h0, 0, 32'h0);

      // 32-bit wrap of PC+4.
      step(0, 0, 0, 32'h0, 1, 32'hFFFF_FFFC);
      step(0, 0, 0, 32'h0, 0, 32'h0);
      chk32("pc_wrap", pc_f, 32'h0000_0000);
      chk32("pc4_wrap", pc4_d, 32'h0000_0000);

      // Randomized mix.
      step(1, 0, 0, 32'h0, 0, 32'h0);
      for (int i = 0; i < 40; i++) begin
         st  = ($urandom_range(0, 3) == 0);
         npc = ($urandom_range(0, 4) == 0);
         jr  = ($urandom_range(0, 6) == 0);
         t1  = BASE + ($urandom_range(0, 1023) << 2) + $urandom_range(0, 3);
         t2  = BASE + ($urandom_range(0, 1023) << 2) + $urandom_range(0, 3);
         step(0, st, npc, t1, jr, t2);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- IF stage of the 5-stage MIPS pipeline: PC register, instruction-memory addressing, and the IF/ID pipeline register.
- Produces PC+4 and the fetched instruction for decode. Decode's next-PC logic computes branch/jump targets from PC+4 and the 26-bit immediate; register-jump targets come from decode as well.
- Consumes the redirect request and stall signal coming back from decode and hazard control.
- Branch delay slot architecture: the instruction after a branch/jump always executes, so this block never flushes.

Parameters:
- RESET_PC, 32'h0000_3000, PC value after reset; also the base address of instruction memory.
- IM_AW, 10, instruction-memory word-address width (depth 2**IM_AW words).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  hazard-unit stall; freezes the PC and IF/ID.
- redirect_npc  in  1  branch taken or j/jal in decode.
- npc_target  in  32  target from decode's next-PC logic.
- redirect_jr  in  1  jr/jalr in decode.
- jr_target  in  32  forwarded rs value.
- im_addr  out  IM_AW  word address to the combinational-read instruction ROM.
- im_rdata  in  32  instruction word at im_addr, same cycle.
- pc_f  out  32  current fetch PC.
- instr_d  out  32  IF/ID instruction.
- pc_d  out  32  IF/ID PC.
- pc4_d  out  32  IF/ID PC+4; feeds decode's next-PC logic.
- valid_d  out  1  IF/ID holds a real fetched instruction.

Behaviour:
- Clock and reset: single clock clk; reset synchronous active-high, sampled only on rising edge of clk.
- On reset edge: pc_f=RESET_PC, instr_d=32'h0 (nop), pc_d=RESET_PC, pc4_d=RESET_PC+4, valid_d=0. Reset overrides stall and redirects.
- Reset asserted mid-operation: the same values load on that edge, with no partial update.
- pc_next priority, evaluated each edge:
  - reset
  - stall: hold
  - redirect_jr: jr_target
  - redirect_npc: npc_target
  - otherwise: pc_f+4
- redirect_jr and redirect_npc both high: decode never legitimately does this; jr wins. This is deterministic and checked by an assertion in the bench.
- Stall with a redirect pending: stall wins and the redirect is dropped. Decode holds the branch instruction during a stall and re-presents the redirect in the first unstalled cycle, so no latch is needed.
- Alignment: pc_next[1:0] is forced to 2'b00 for every source, so pc_f[1:0] is always 0.
- Arithmetic: all additions are 32-bit and wrap modulo 2**32 (0xFFFF_FFFC+4 = 0x0000_0000).
- im_addr = (pc_f - RESET_PC)[IM_AW+1:2]. It is combinational from pc_f, so fetch latency is 0 cycles within IF.
- Out-of-range PCs wrap modulo the memory depth; no error flag.
- IF/ID register, on a non-reset edge:
  - stall=1: all of instr_d, pc_d, pc4_d, valid_d hold.
  - stall=0: instr_d<=im_rdata, pc_d<=pc_f, pc4_d<=pc_f+4, valid_d<=1.
- Latency: the instruction at PC X appears on instr_d one edge after pc_f==X, provided stall=0.
- Redirect timing: the branch is in D while its delay slot is in F. The delay slot enters IF/ID on the same edge that pc_f loads the target; the target instruction reaches D on the following edge.
- No handshake with memory: the ROM is combinational, so no wait states exist.

Decomposition:
- Shared CPU package holds:
  - RESET_PC
  - NOP encoding 32'h0
  - PC-source select localparams: PCSEL_SEQ, PCSEL_NPC, PCSEL_JR, PCSEL_HOLD
- One natural sub-module: pc_reg. It contains the PC flop, the priority mux and the alignment masking.
- The IF/ID register stays inline in fetch_stage.

Test Plan:
- Reset then 4 free-running cycles, im_rdata = 0x2400_0001+word index → pc_f sequence 0x3000, 0x3004, 0x3008, 0x300C; instr_d lags by one edge; valid_d 0→1 after the first edge.
- redirect_npc=1, npc_target=0x3040 while pc_f=0x3008 → next pc_f=0x3040; instr_d = word at 0x3008 (delay slot); pc4_d=0x300C.
- stall=1 for 3 cycles with redirect_jr=1, jr_target=0x3100 → pc_f and all IF/ID outputs frozen. After stall drops with redirect still high → pc_f=0x3100 on the next edge.
- redirect_jr and redirect_npc both high (jr_target=0x3200, npc_target=0x3300) → pc_f=0x3200. Separately, jr_target=0x3203 → pc_f=0x3200.
- reset pulsed mid-stream at pc_f=0x3050 with stall=1 → next edge pc_f=0x3000, instr_d=0, valid_d=0.
- jr_target=0x0000_2FFC (below base) → pc_f=0x2FFC, im_addr = all ones (wrap to 2**IM_AW-1); no X on any output.
